debounce_strobe: RTL and testbench
==================================

# debounce_strobe

Upstream conditioning stage for the level-sensitive D latch. Takes a raw, asynchronous, possibly bouncing single-bit input and synchronises it into the `clk` domain. A new level is accepted only after it has been stable for a programmable number of cycles; the stage then presents the new level on `d` with a one-cycle `en` strobe. The downstream latch's `d`/`en` inputs connect directly to these outputs, so the latch only ever sees clean, clock-aligned data and enable.

## Interface
- `STABLE_CYCLES`, default 8: consecutive synchronised cycles a new level must hold before it is committed; legal range ≥ 1.
- `RESET_VAL`, default 1'b0: value of `d` and of both synchroniser flops in reset.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `d_in`  input  1  raw asynchronous input (switch/pin).
- `d`  output  1  debounced level, registered; feeds latch `d`.
- `en`  output  1  registered one-cycle strobe, high in the cycle `d` takes a new value; feeds latch `en`.
- `busy`  output  1  high while state ≠ IDLE (decoded from state register).

## Operation
- Synchroniser: `d_in` → `s1` → `s2`, two flops, both reset to `RESET_VAL`.
- Counter `cnt`, width ceil(log2(STABLE_CYCLES)) (min 1 bit), reset 0.
- FSM states: IDLE, COUNT, COMMIT; reset state IDLE.
  - IDLE: if `s2 != d` → COUNT with `cnt` = 0; else stay.
  - COUNT, `s2 == d` (bounce back): → IDLE, `cnt` = 0, no strobe.
  - COUNT, `s2 != d` and `cnt == STABLE_CYCLES-1`: → COMMIT; at this same edge `d` <= `s2`, `en` <= 1.
  - COUNT, `s2 != d` otherwise: `cnt` increments, stay.
  - COMMIT: `en` <= 0; → IDLE unconditionally; `s2` is not examined this cycle.
- `d` changes only on the edge entering COMMIT; `en` is high for exactly that one cycle. `d` is valid and stable for the whole `en` pulse and after it.
- Reset values: `d` = `RESET_VAL`, `en` = 0, `busy` = 0.

## Timing
- Latency: when `d_in` changes between edges 0 and 1 and then holds, `d` and `en` update at edge `STABLE_CYCLES`+3 (edge 11 for the default).
  - edges 1–2: synchroniser;
  - edge 3: IDLE→COUNT;
  - `STABLE_CYCLES` cycles spent in COUNT.
- `busy` rises at edge 3 and falls at edge `STABLE_CYCLES`+4.
- A bounce seen on `s2` in any COUNT cycle, including the final one, aborts: no `en`, `d` unchanged. The count restarts from 0 on the next IDLE→COUNT.
- A `d_in` change arriving during COMMIT is handled by the IDLE decision on the following cycle. Minimum spacing between `en` pulses is `STABLE_CYCLES`+2 cycles.
- Asynchronous `rst` mid-COUNT or mid-COMMIT: all state returns immediately to reset values and `en` drops to 0 at once. After reset deassertion there is no spurious strobe, because the synchroniser and `d` share `RESET_VAL`.
- `STABLE_CYCLES` = 1: exactly one COUNT cycle, then commit.

## Structure
- Shared package: FSM state enum (IDLE = 2'd0, COUNT = 2'd1, COMMIT = 2'd2) and default constants for `STABLE_CYCLES` and `RESET_VAL`. The enum is reused by other input-conditioning stages.
- One sub-module: `sync_2ff` (two-flop synchroniser, parameterised reset value, async active-high reset).
- FSM, counter and output registers live in `debounce_strobe` itself.

## Test plan
- Reset, `d_in` held 0, 50 cycles → `d` = 0, `en` never high, `busy` = 0.
- `d_in` 0→1 held → `d` = 1 and a single-cycle `en` at edge 11; `busy` high from edge 3 through edge 11; the downstream latch's `q` becomes 1.
- `d_in` 0→1, back to 0 after 5 cycles in COUNT, then re-asserted → the first attempt gives no `en` and `d` stays 0; the second attempt commits 11 edges after re-assertion.
- Glitch timed so `s2` returns to `d` exactly on the `cnt` == 7 edge → no `en`, state back to IDLE.
- `rst` pulsed mid-COUNT (`cnt` = 4) → `busy` = 0 immediately, `d` = `RESET_VAL`, no `en` afterwards while `d_in` = `RESET_VAL`.
- `STABLE_CYCLES` = 1, `d_in` toggled every 4 cycles → every toggle commits at edge 4 after its change, with one `en` pulse per toggle.

Source files
------------

// File: rtl/debounce_strobe_pkg.sv
// Shared types and defaults for the input-conditioning stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_strobe_pkg;

  // Conditioning FSM states; the encoding is shared with sibling stages.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int   STABLE_CYCLES_DEFAULT = 8;
  localparam logic RESET_VAL_DEFAULT     = 1'b0;

endpackage

// File: rtl/debounce_strobe_sync_2ff.sv
// Two-flop synchroniser that brings an asynchronous pin into the clk domain.
// Latency: 2 clk edges from a stable input to sync_out.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic s1;

  // Two-stage shift; both stages reset to the same level as the debounced output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      s1       <= async_in;
      sync_out <= s1;
    end
  end

endmodule

// File: rtl/debounce_strobe.sv
// Debounces a raw pin and emits the new level on d with a one-cycle en strobe.
// Latency: STABLE_CYCLES+3 edges from a clean input change to d/en.
// Backpressure: none; the strobe is fire-and-forget toward the latch.
module debounce_strobe
  import debounce_strobe_pkg::*;
#(
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic RESET_VAL     = RESET_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d,
  output logic en,
  output logic busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .RESET_VAL(RESET_VAL)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (d_in),
    .sync_out (s2)
  );

  // Stability FSM: a differing level must survive every COUNT cycle before it
  // is committed; COMMIT is a one-cycle holdoff that ignores s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      d     <= RESET_VAL;
      en    <= 1'b0;
    end else begin
      en <= 1'b0;
      case (state)
        IDLE: begin
          if (s2 != d) begin
            state <= COUNT;
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (s2 == d) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= COMMIT;
            cnt   <= '0;
            d     <= s2;
            en    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_debounce_strobe.sv
module tb_debounce_strobe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in8 = 1'b0;
  logic d_in1 = 1'b0;
  logic d8, en8, busy8;
  logic d1, en1, busy1;
  logic q;

  int passed = 0;
  int checks = 0;
  int failed = 0;
  int en8_seen = 0;
  int en1_seen = 0;

  always #5 clk = ~clk;

  debounce_strobe u8 (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in8),
    .d    (d8),
    .en   (en8),
    .busy (busy8)
  );

  debounce_strobe #(
    .STABLE_CYCLES (1),
    .RESET_VAL     (1'b0)
  ) u1 (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in1),
    .d    (d1),
    .en   (en1),
    .busy (busy1)
  );

  // Downstream level-sensitive latch fed by the strobe.
  always_latch if (en8) q <= d8;

  // Reference model: the pin is seen two edges late; a level is accepted once
  // it has differed from d on STABLE+1 consecutive evaluated edges, and the
  // edge right after an acceptance is not evaluated.
  localparam int S_M [2] = '{8, 1};
  logic mp1 [2] = '{1'b0, 1'b0};
  logic mp2 [2] = '{1'b0, 1'b0};
  logic md  [2] = '{1'b0, 1'b0};
  logic men [2] = '{1'b0, 1'b0};
  int   run [2] = '{0, 0};
  bit   hold[2] = '{1'b0, 1'b0};
  logic seen_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mp1[i] = 1'b0; mp2[i] = 1'b0; md[i] = 1'b0;
        men[i] = 1'b0; run[i] = 0;    hold[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        seen_m = mp2[i];
        mp2[i] = mp1[i];
        mp1[i] = (i == 0) ? d_in8 : d_in1;
        men[i] = 1'b0;
        if (hold[i]) begin
          hold[i] = 1'b0;
        end else if (seen_m != md[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == S_M[i] + 1) begin
            md[i] = seen_m; men[i] = 1'b1; run[i] = 0; hold[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("m8_d", d8, md[0]);
    chk("m8_en", en8, men[0]);
    chk("m8_busy", busy8, (run[0] > 0) || hold[0]);
    chk("m1_d", d1, md[1]);
    chk("m1_en", en1, men[1]);
    chk("m1_busy", busy1, (run[1] > 0) || hold[1]);
  endtask

  // Advance n edges; outputs are checked on the falling edge after each one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (en8) en8_seen++;
      if (en1) en1_seen++;
      model_check();
    end
  endtask

  // Drive a new level on the 8-cycle instance and check the exact commit edge.
  task automatic commit_check(input logic v);
    d_in8 = v;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("c_en", en8, k == 11);
      chk("c_busy", busy8, (k >= 3) && (k <= 11));
      chk("c_d", d8, (k >= 11) ? v : ~v);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_d", d8, 1'b0);
    chk("rst_en", en8, 1'b0);
    chk("rst_busy", busy8, 1'b0);

    // Quiet input: nothing happens.
    en8_seen = 0;
    cyc(50);
    chk_n("idle_no_en", en8_seen, 0);
    chk("idle_d", d8, 1'b0);
    chk("idle_busy", busy8, 1'b0);

    // Clean rising edge commits at edge 11 and loads the latch.
    commit_check(1'b1);
    chk("latch_q", q, 1'b1);
    d_in8 = 1'b0;
    cyc(20);
    chk("back_to_0", d8, 1'b0);

    // Bounce after five COUNT cycles aborts; retry commits normally.
    en8_seen = 0;
    d_in8 = 1'b1;
    cyc(5);
    d_in8 = 1'b0;
    cyc(3);
    chk("bounce_idle", busy8, 1'b0);
    cyc(10);
    chk_n("bounce_no_en", en8_seen, 0);
    chk("bounce_d", d8, 1'b0);
    commit_check(1'b1);
    d_in8 = 1'b0;
    cyc(20);

    // Glitch landing on the final COUNT evaluation.
    en8_seen = 0;
    d_in8 = 1'b1;
    cyc(8);
    d_in8 = 1'b0;
    cyc(2);
    chk("last_busy", busy8, 1'b1);
    cyc(1);
    chk("last_abort_busy", busy8, 1'b0);
    chk("last_abort_en", en8, 1'b0);
    cyc(10);
    chk_n("last_no_en", en8_seen, 0);
    chk("last_d", d8, 1'b0);

    // Asynchronous reset in the middle of COUNT.
    d_in8 = 1'b1;
    cyc(7);
    chk("midcnt_busy", busy8, 1'b1);
    d_in8 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstcnt_busy", busy8, 1'b0);
    chk("rstcnt_d", d8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en8_seen = 0;
    cyc(20);
    chk_n("rstcnt_no_en", en8_seen, 0);

    // Asynchronous reset during the strobe drops en at once.
    d_in8 = 1'b1;
    cyc(11);
    chk("commit_en", en8, 1'b1);
    d_in8 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstcom_en", en8, 1'b0);
    chk("rstcom_d", d8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en8_seen = 0;
    cyc(20);
    chk_n("rstcom_no_en", en8_seen, 0);

    // Single-cycle stability: each toggle commits four edges later.
    en1_seen = 0;
    for (int t = 0; t < 6; t++) begin
      d_in1 = ~d_in1;
      for (int k = 1; k <= 4; k++) begin
        cyc(1);
        chk("s1_en", en1, k == 4);
        chk("s1_d", d1, (k == 4) ? d_in1 : ~d_in1);
      end
    end
    chk_n("s1_pulses", en1_seen, 6);

    // Random bouncing with occasional asynchronous resets.
    for (int blk = 0; blk < 15; blk++) begin
      int rate8;
      int rate1;
      rate8 = $urandom_range(2, 30);
      rate1 = $urandom_range(1, 6);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, rate8 - 1) == 0) d_in8 = 1'($urandom);
        if ($urandom_range(0, rate1 - 1) == 0) d_in1 = 1'($urandom);
        if ($urandom_range(0, 399) == 0) begin
          #1 rst = 1'b1;
          #2 rst = 1'b0;
        end
        cyc(1);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
